// File: rtl/exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : exception_ctrl
// Brief    : Memory-stage exception arbiter for the sram_like MIPS core.
//            Prioritises per-instruction exception flags and pending
//            interrupts, reports one exception per accept to CP0, flushes
//            the pipeline, waits for outstanding sram_like transactions to
//            drain and then issues a one-cycle PC redirect.
// Revision : 1.0 - initial release
// ============================================================================
module exception_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_i,
  input  logic        stall_mem_i,
  input  logic [31:0] pc_i,
  input  logic        is_in_delayslot_i,
  input  logic        exc_adel_if_i,
  input  logic        exc_ri_i,
  input  logic        exc_sys_i,
  input  logic        exc_bp_i,
  input  logic        exc_ov_i,
  input  logic        exc_eret_i,
  input  logic        exc_adel_ld_i,
  input  logic        exc_ades_st_i,
  input  logic [31:0] data_addr_i,
  input  logic [31:0] cp0_status_i,
  input  logic [31:0] cp0_cause_i,
  input  logic [31:0] cp0_epc_i,
  input  logic        cp0_we_i,
  input  logic [4:0]  cp0_waddr_i,
  input  logic [31:0] cp0_wdata_i,
  input  logic        inst_busy_i,
  input  logic        data_busy_i,
  output logic [31:0] excepttype_o,
  output logic [31:0] current_inst_addr_o,
  output logic        is_in_delayslot_o,
  output logic [31:0] bad_addr_o,
  output logic        flush_o,
  output logic        newpc_valid_o,
  output logic [31:0] newpc_o
);

  localparam logic [4:0]  CP0_STATUS = 5'd12;
  localparam logic [4:0]  CP0_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_EPC    = 5'd14;

  localparam logic [31:0] CODE_INT   = 32'h0000_0001;
  localparam logic [31:0] CODE_ADEL  = 32'h0000_0004;
  localparam logic [31:0] CODE_ADES  = 32'h0000_0005;
  localparam logic [31:0] CODE_SYS   = 32'h0000_0008;
  localparam logic [31:0] CODE_BP    = 32'h0000_0009;
  localparam logic [31:0] CODE_RI    = 32'h0000_000A;
  localparam logic [31:0] CODE_OV    = 32'h0000_000C;
  localparam logic [31:0] CODE_ERET  = 32'h0000_000E;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DRAIN    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] target_q, target_d;
  logic [31:0] newpc_q, newpc_d;

  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic        int_pending;
  logic        any_source;
  logic        accept;
  logic [31:0] exc_code;
  logic [31:0] exc_bad_addr;
  logic        exc_is_eret;
  logic        unused_ok;

  // Bypass an mtc0 in flight so the arbiter sees the CP0 state the
  // instruction in mem would observe; only cause IP[1:0] is software-writable.
  always_comb begin
    eff_status = cp0_status_i;
    eff_cause  = cp0_cause_i;
    eff_epc    = cp0_epc_i;
    if (cp0_we_i && (cp0_waddr_i == CP0_STATUS)) begin
      eff_status = cp0_wdata_i;
    end
    if (cp0_we_i && (cp0_waddr_i == CP0_CAUSE)) begin
      eff_cause[9:8] = cp0_wdata_i[9:8];
    end
    if (cp0_we_i && (cp0_waddr_i == CP0_EPC)) begin
      eff_epc = cp0_wdata_i;
    end
  end

  // Interrupt needs a masked-in pending line, IE set and not at exception level.
  assign int_pending = (|(eff_status[15:8] & eff_cause[15:8]))
                       && eff_status[0] && !eff_status[1];

  assign any_source = int_pending | exc_adel_if_i | exc_ri_i | exc_sys_i
                    | exc_bp_i | exc_ov_i | exc_adel_ld_i | exc_ades_st_i
                    | exc_eret_i;

  assign accept = !rst && (state_q == IDLE) && inst_valid_i && !stall_mem_i
                  && any_source;

  // Fixed-priority pick of a single winning source; bad address follows the winner.
  always_comb begin
    exc_code     = 32'd0;
    exc_bad_addr = 32'd0;
    exc_is_eret  = 1'b0;
    if (int_pending) begin
      exc_code = CODE_INT;
    end else if (exc_adel_if_i) begin
      exc_code     = CODE_ADEL;
      exc_bad_addr = pc_i;
    end else if (exc_ri_i) begin
      exc_code = CODE_RI;
    end else if (exc_sys_i) begin
      exc_code = CODE_SYS;
    end else if (exc_bp_i) begin
      exc_code = CODE_BP;
    end else if (exc_ov_i) begin
      exc_code = CODE_OV;
    end else if (exc_adel_ld_i) begin
      exc_code     = CODE_ADEL;
      exc_bad_addr = data_addr_i;
    end else if (exc_ades_st_i) begin
      exc_code     = CODE_ADES;
      exc_bad_addr = data_addr_i;
    end else if (exc_eret_i) begin
      exc_code    = CODE_ERET;
      exc_is_eret = 1'b1;
    end
  end

  // Bits of the forwarded CP0 words that play no part in arbitration.
  assign unused_ok = ^{eff_status[31:16], eff_status[7:2],
                       eff_cause[31:16], eff_cause[7:0]};

  // Next-state and output decode; everything is held at zero while in reset.
  always_comb begin
    state_d             = state_q;
    target_d            = target_q;
    newpc_d             = newpc_q;
    excepttype_o        = 32'd0;
    current_inst_addr_o = 32'd0;
    is_in_delayslot_o   = 1'b0;
    bad_addr_o          = 32'd0;
    flush_o             = 1'b0;
    newpc_valid_o       = 1'b0;
    if (!rst) begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            excepttype_o        = exc_code;
            current_inst_addr_o = pc_i;
            is_in_delayslot_o   = is_in_delayslot_i;
            bad_addr_o          = exc_bad_addr;
            flush_o             = 1'b1;
            target_d            = exc_is_eret ? eff_epc : EXC_VECTOR;
            state_d             = DRAIN;
          end
        end
        DRAIN: begin
          flush_o = 1'b1;
          // Redirect only once neither sram_like port has a request outstanding.
          if (!inst_busy_i && !data_busy_i) begin
            newpc_d = target_q;
            state_d = REDIRECT;
          end
        end
        REDIRECT: begin
          flush_o       = 1'b1;
          newpc_valid_o = 1'b1;
          state_d       = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  assign newpc_o = newpc_q;

  // State, latched redirect target and redirect PC registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      target_q <= 32'd0;
      newpc_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      newpc_q  <= newpc_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_exception_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_exception_ctrl
// Brief    : Scoreboard bench for exception_ctrl. The driver pushes expected
//            exception reports and redirects; a monitor pops and compares
//            whenever the DUT emits an exception pulse or a redirect strobe.
// Revision : 1.0 - initial release
// ============================================================================
module tb_exception_ctrl;

  localparam logic [31:0] VEC = 32'hBFC00380;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_i, stall_mem_i, is_in_delayslot_i;
  logic [31:0] pc_i, data_addr_i;
  logic        exc_adel_if_i, exc_ri_i, exc_sys_i, exc_bp_i, exc_ov_i;
  logic        exc_eret_i, exc_adel_ld_i, exc_ades_st_i;
  logic [31:0] cp0_status_i, cp0_cause_i, cp0_epc_i, cp0_wdata_i;
  logic        cp0_we_i;
  logic [4:0]  cp0_waddr_i;
  logic        inst_busy_i, data_busy_i;
  logic [31:0] excepttype_o, current_inst_addr_o, bad_addr_o, newpc_o;
  logic        is_in_delayslot_o, flush_o, newpc_valid_o;

  exception_ctrl #(.EXC_VECTOR(VEC)) dut (
    .clk(clk), .rst(rst),
    .inst_valid_i(inst_valid_i), .stall_mem_i(stall_mem_i),
    .pc_i(pc_i), .is_in_delayslot_i(is_in_delayslot_i),
    .exc_adel_if_i(exc_adel_if_i), .exc_ri_i(exc_ri_i),
    .exc_sys_i(exc_sys_i), .exc_bp_i(exc_bp_i), .exc_ov_i(exc_ov_i),
    .exc_eret_i(exc_eret_i), .exc_adel_ld_i(exc_adel_ld_i),
    .exc_ades_st_i(exc_ades_st_i), .data_addr_i(data_addr_i),
    .cp0_status_i(cp0_status_i), .cp0_cause_i(cp0_cause_i),
    .cp0_epc_i(cp0_epc_i), .cp0_we_i(cp0_we_i),
    .cp0_waddr_i(cp0_waddr_i), .cp0_wdata_i(cp0_wdata_i),
    .inst_busy_i(inst_busy_i), .data_busy_i(data_busy_i),
    .excepttype_o(excepttype_o), .current_inst_addr_o(current_inst_addr_o),
    .is_in_delayslot_o(is_in_delayslot_o), .bad_addr_o(bad_addr_o),
    .flush_o(flush_o), .newpc_valid_o(newpc_valid_o), .newpc_o(newpc_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] pc;
    logic        ds;
    logic [31:0] bad;
  } exc_t;

  typedef struct packed {
    logic [31:0] tgt;
    logic [31:0] lat;
  } redir_t;

  exc_t   exc_q[$];
  redir_t redir_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int acc_cyc  = 0;
  int flush_run = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: pop and compare on every exception pulse and redirect strobe.
  always @(negedge clk) begin
    exc_t   e;
    redir_t r;
    if (rst) begin
      flush_run = 0;
    end else begin
      if (flush_o) flush_run++;
      else flush_run = 0;
      if (flush_o && (excepttype_o != 32'd0)) begin
        acc_cyc = cyc;
        if (exc_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_exc: actual excepttype 0x%08h required no exception",
                   excepttype_o);
        end else begin
          e = exc_q.pop_front();
          check("excepttype", excepttype_o, e.code);
          check("current_inst_addr", current_inst_addr_o, e.pc);
          check("is_in_delayslot", {31'd0, is_in_delayslot_o}, {31'd0, e.ds});
          check("bad_addr", bad_addr_o, e.bad);
        end
      end
      if (newpc_valid_o) begin
        if (redir_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_redirect: actual newpc 0x%08h required no redirect",
                   newpc_o);
        end else begin
          r = redir_q.pop_front();
          check("newpc", newpc_o, r.tgt);
          check("redirect_latency", cyc - acc_cyc, r.lat);
          check("flush_run", flush_run, r.lat + 1);
        end
      end
    end
  end

  task automatic clear_inputs();
    inst_valid_i = 0; stall_mem_i = 0; pc_i = 0; is_in_delayslot_i = 0;
    exc_adel_if_i = 0; exc_ri_i = 0; exc_sys_i = 0; exc_bp_i = 0;
    exc_ov_i = 0; exc_eret_i = 0; exc_adel_ld_i = 0; exc_ades_st_i = 0;
    data_addr_i = 0; cp0_status_i = 0; cp0_cause_i = 0; cp0_epc_i = 0;
    cp0_we_i = 0; cp0_waddr_i = 0; cp0_wdata_i = 0;
    inst_busy_i = 0; data_busy_i = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_exc(input logic [31:0] code, input logic [31:0] pc,
                            input logic ds, input logic [31:0] bad);
    exc_t e;
    e.code = code; e.pc = pc; e.ds = ds; e.bad = bad;
    exc_q.push_back(e);
  endtask

  task automatic expect_redir(input logic [31:0] tgt, input logic [31:0] lat);
    redir_t r;
    r.tgt = tgt; r.lat = lat;
    redir_q.push_back(r);
  endtask

  // Bounded wait for the scoreboard to empty, then let the FSM settle.
  task automatic drain_wait(input string name);
    int n = 0;
    while (((exc_q.size() != 0) || (redir_q.size() != 0)) && (n < 50)) begin
      step();
      n++;
    end
    if (n >= 50) begin
      n_checks++;
      n_fail++;
      $display("FAIL timeout_%s: actual %0d entries pending required 0", name,
               exc_q.size() + redir_q.size());
      exc_q.delete();
      redir_q.delete();
    end
    repeat (2) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running required finished");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_inputs();
    rst = 1;
    repeat (3) step();
    check("rst_flush", {31'd0, flush_o}, 32'd0);
    check("rst_newpc_valid", {31'd0, newpc_valid_o}, 32'd0);
    check("rst_newpc", newpc_o, 32'd0);
    check("rst_excepttype", excepttype_o, 32'd0);
    rst = 0;
    step();

    // Syscall, no busy: pulse at T, redirect to vector at T+2.
    inst_valid_i = 1; pc_i = 32'hBFC00100; exc_sys_i = 1;
    expect_exc(32'h8, 32'hBFC00100, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("sys");

    // Misaligned load in a delay slot.
    inst_valid_i = 1; pc_i = 32'h80000010; is_in_delayslot_i = 1;
    exc_adel_ld_i = 1; data_addr_i = 32'h80001002;
    expect_exc(32'h4, 32'h80000010, 1'b1, 32'h80001002);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("adel_ld");

    // ri + ov + sys together: ri wins, single code.
    inst_valid_i = 1; pc_i = 32'h80000020; exc_ri_i = 1; exc_ov_i = 1; exc_sys_i = 1;
    expect_exc(32'hA, 32'h80000020, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("ri_prio");

    // Pending interrupt beats overflow.
    inst_valid_i = 1; pc_i = 32'h80000030; exc_ov_i = 1;
    cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00008000;
    expect_exc(32'h1, 32'h80000030, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("int");

    // EXL set masks the interrupt: overflow reported.
    inst_valid_i = 1; pc_i = 32'h80000040; exc_ov_i = 1;
    cp0_status_i = 32'h0000FF03; cp0_cause_i = 32'h00008000;
    expect_exc(32'hC, 32'h80000040, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("int_exl");

    // eret with EPC forwarded from an mtc0 in the same cycle.
    inst_valid_i = 1; pc_i = 32'h80000050; exc_eret_i = 1;
    cp0_epc_i = 32'h11111110; cp0_we_i = 1; cp0_waddr_i = 5'd14;
    cp0_wdata_i = 32'h80000400;
    expect_exc(32'hE, 32'h80000050, 1'b0, 32'd0);
    expect_redir(32'h80000400, 2);
    step(); clear_inputs(); drain_wait("eret");

    // Misaligned fetch: bad address is the PC.
    inst_valid_i = 1; pc_i = 32'h80000063; exc_adel_if_i = 1;
    data_addr_i = 32'h12345678;
    expect_exc(32'h4, 32'h80000063, 1'b0, 32'h80000063);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("adel_if");

    // Misaligned store.
    inst_valid_i = 1; pc_i = 32'h80000070; exc_ades_st_i = 1;
    data_addr_i = 32'h80002001;
    expect_exc(32'h5, 32'h80000070, 1'b0, 32'h80002001);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("ades_st");

    // Software interrupt raised through forwarded cause IP0.
    inst_valid_i = 1; pc_i = 32'h80000080; exc_sys_i = 1;
    cp0_status_i = 32'h00000101; cp0_we_i = 1; cp0_waddr_i = 5'd13;
    cp0_wdata_i = 32'h00000100;
    expect_exc(32'h1, 32'h80000080, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("cause_fwd");

    // Stalled syscall and a bubble with pending interrupt are not accepted.
    inst_valid_i = 1; stall_mem_i = 1; pc_i = 32'h80000090; exc_sys_i = 1;
    repeat (2) step();
    clear_inputs();
    cp0_status_i = 32'h0000FF01; cp0_cause_i = 32'h00008000;
    repeat (2) step();
    check("bubble_no_flush", {31'd0, flush_o}, 32'd0);
    inst_valid_i = 1; pc_i = 32'h800000A0;
    expect_exc(32'h1, 32'h800000A0, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("int_wait");

    // Break with data side busy for 3 cycles; a syscall during DRAIN is ignored.
    inst_valid_i = 1; pc_i = 32'h800000B0; exc_bp_i = 1;
    expect_exc(32'h9, 32'h800000B0, 1'b0, 32'd0);
    expect_redir(VEC, 5);
    step(); clear_inputs();
    data_busy_i = 1; inst_valid_i = 1; pc_i = 32'h800000C0; exc_sys_i = 1;
    repeat (3) step();
    clear_inputs(); drain_wait("bp_busy");

    // Reset while in DRAIN: no redirect follows.
    inst_valid_i = 1; pc_i = 32'h800000D0; exc_bp_i = 1;
    expect_exc(32'h9, 32'h800000D0, 1'b0, 32'd0);
    step(); clear_inputs();
    data_busy_i = 1;
    repeat (2) step();
    rst = 1;
    step();
    rst = 0; data_busy_i = 0;
    repeat (4) step();
    check("abort_flush", {31'd0, flush_o}, 32'd0);
    check("abort_newpc", newpc_o, 32'd0);
    drain_wait("abort");

    // Recovery after abort.
    inst_valid_i = 1; pc_i = 32'h800000E0; exc_sys_i = 1;
    expect_exc(32'h8, 32'h800000E0, 1'b0, 32'd0);
    expect_redir(VEC, 2);
    step(); clear_inputs(); drain_wait("recover");

    check("exc_q_empty", exc_q.size(), 32'd0);
    check("redir_q_empty", redir_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
